// File: rtl/framing_rx_ring.sv
// Multi-slot Ethernet RX ring: frames from the byte stream are queued in SLOTS fixed-size slots
// and drained over the LSU bus. Optional FRAMING_RX_BADFRAME_DROP_EN drops frames flagged bad by FCS.
module framing_rx_ring #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 2048,
  parameter int DROP_W     = 16
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  input  logic [13:0] core_lsu_addr,
  input  logic [63:0] core_lsu_wdata,
  input  logic        ce_d,
  input  logic        we_d,
  input  logic        framing_sel,
  output logic [63:0] framing_rdata,
  output logic        eth_irq
);

  localparam int SW    = $clog2(SLOTS);
  localparam int AW    = $clog2(SLOT_BYTES);
  localparam int LW    = AW + 1;
  localparam int CW    = SW + 1;
  localparam int WORDS = SLOTS * SLOT_BYTES / 8;
  localparam logic [LW-1:0] PTR_MAX = LW'(SLOT_BYTES);
  localparam logic [CW-1:0] FULL    = CW'(SLOTS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECV    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]        state;
  logic [LW-1:0]     wptr;
  logic              trunc_q;
  logic [SW-1:0]     head;
  logic [SW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [11:0]       len_q [SLOTS];
  logic              err_q [SLOTS];
  logic [DROP_W-1:0] drop_cnt;
  logic              irq_en;
  logic [63:0]       mem [WORDS];
  logic [63:0]       rd_buf_q;
  logic [63:0]       rd_reg_q;
  logic              use_buf_q;

  logic          byte_wr;
  logic          commit_try;
  logic          drop_try;
  logic          commit;
  logic          drop_inc;
  logic          frame_trunc;
  logic [LW-1:0] frame_len;

  always_comb begin
    byte_wr    = 1'b0;
    commit_try = 1'b0;
    drop_try   = 1'b0;
    if (rx_tvalid) begin
      case (state)
        IDLE: begin
          if (count != FULL) begin
            byte_wr    = 1'b1;
            commit_try = rx_tlast;
          end else begin
            drop_try = rx_tlast;
          end
        end
        RECV: begin
          byte_wr    = (wptr != PTR_MAX);
          commit_try = rx_tlast;
        end
        DISCARD: drop_try = rx_tlast;
        default: ;
      endcase
    end
  end

  // A last byte that lands past the slot end still marks the frame truncated.
  assign frame_len   = byte_wr ? wptr + LW'(1) : wptr;
  assign frame_trunc = trunc_q | (commit_try & ~byte_wr);

`ifdef FRAMING_RX_BADFRAME_DROP_EN
  logic bad;
  assign bad      = rx_tuser & ~frame_trunc;
  assign commit   = commit_try & ~bad;
  assign drop_inc = drop_try | (commit_try & bad);
`else
  assign commit   = commit_try;
  assign drop_inc = drop_try;
`endif

  logic       rd;
  logic       reg_wr;
  logic       pop;
  logic       drop_clr;
  logic       ctrl_wr;
  logic [1:0] win;
  logic [3:0] idx;

  assign win      = core_lsu_addr[13:12];
  assign idx      = core_lsu_addr[6:3];
  assign rd       = ce_d & framing_sel & ~we_d;
  assign reg_wr   = ce_d & framing_sel & we_d & (win == 2'b01);
  assign ctrl_wr  = reg_wr & (idx == 4'd0);
  assign pop      = reg_wr & (idx == 4'd3) & (count != '0);
  assign drop_clr = reg_wr & (idx == 4'd4);

  logic [63:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (win == 2'b01) begin
      case (idx)
        4'd0: rd_val[0] = irq_en;
        4'd1: begin
          rd_val[SW-1:0]        = head;
          rd_val[8 +: SW]       = tail;
          rd_val[16 +: CW]      = count;
          rd_val[32 +: DROP_W]  = drop_cnt;
        end
        4'd2: begin
          if (count != '0) begin
            rd_val[11:0] = len_q[tail];
            rd_val[16]   = err_q[tail];
          end
        end
        default: ;
      endcase
    end
  end

  // Slot storage has no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge msoc_clk) begin
    if (byte_wr)
      mem[{head, wptr[AW-1:3]}][{wptr[2:0], 3'b000} +: 8] <= rx_tdata;
    if (rd && win == 2'b00)
      rd_buf_q <= mem[{tail, core_lsu_addr[AW-1:3]}];
  end

  assign framing_rdata = use_buf_q ? rd_buf_q : rd_reg_q;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wptr      <= '0;
      trunc_q   <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      irq_en    <= 1'b0;
      eth_irq   <= 1'b0;
      rd_reg_q  <= '0;
      use_buf_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        len_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else begin
      if (rx_tvalid) begin
        case (state)
          IDLE:    if (!rx_tlast) state <= (count != FULL) ? RECV : DISCARD;
          RECV,
          DISCARD: if (rx_tlast) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (rx_tlast) begin
          wptr    <= '0;
          trunc_q <= 1'b0;
        end else begin
          if (byte_wr)
            wptr <= wptr + LW'(1);
          if (state == RECV && !byte_wr)
            trunc_q <= 1'b1;
        end
      end

      if (commit) begin
        len_q[head] <= 12'(frame_len);
        err_q[head] <= rx_tuser | frame_trunc;
        head        <= head + SW'(1);
      end
      if (pop)
        tail <= tail + SW'(1);
      case ({commit, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (drop_clr)
        drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);

      if (ctrl_wr)
        irq_en <= core_lsu_wdata[0];
      eth_irq <= irq_en & (count != '0);

      if (rd) begin
        use_buf_q <= (win == 2'b00);
        rd_reg_q  <= rd_val;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{core_lsu_wdata[63:1], core_lsu_addr[11:7], core_lsu_addr[2:0]};

endmodule

// File: tb/tb_framing_rx_ring.sv
// Bench for framing_rx_ring: register/buffer reads go through a scoreboard queue,
// a vector table covers the first frame, and hand sequences cover ring corner cases.
module tb_framing_rx_ring;

  localparam logic [13:0] A_CTRL    = 14'h1000;
  localparam logic [13:0] A_STATUS  = 14'h1008;
  localparam logic [13:0] A_RXLEN   = 14'h1010;
  localparam logic [13:0] A_POP     = 14'h1018;
  localparam logic [13:0] A_DROPCLR = 14'h1020;

  logic        msoc_clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tuser;
  logic [13:0] core_lsu_addr;
  logic [63:0] core_lsu_wdata;
  logic        ce_d;
  logic        we_d;
  logic        framing_sel;
  logic [63:0] framing_rdata;
  logic        eth_irq;

  framing_rx_ring #(.SLOTS(4), .SLOT_BYTES(2048), .DROP_W(16)) dut (
    .msoc_clk      (msoc_clk),
    .rstn          (rstn),
    .rx_tdata      (rx_tdata),
    .rx_tvalid     (rx_tvalid),
    .rx_tlast      (rx_tlast),
    .rx_tuser      (rx_tuser),
    .core_lsu_addr (core_lsu_addr),
    .core_lsu_wdata(core_lsu_wdata),
    .ce_d          (ce_d),
    .we_d          (we_d),
    .framing_sel   (framing_sel),
    .framing_rdata (framing_rdata),
    .eth_irq       (eth_irq)
  );

  always #5 msoc_clk = ~msoc_clk;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  function automatic logic [63:0] status_word(int h, int t, int c, int d);
    return {16'h0, 16'(d), 8'h0, 8'(c), 8'(t), 8'(h)};
  endfunction

  function automatic logic [63:0] pat_word(int seed, int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++)
      r[b*8 +: 8] = 8'(seed + w*8 + b);
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Read data lands one cycle after the request; compare it in the following low phase.
  task automatic read_monitor();
    logic        pend;
    logic [63:0] e;
    string       nm;
    forever begin
      @(posedge msoc_clk);
      pend = ce_d & framing_sel & ~we_d;
      @(negedge msoc_clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read got %h expected none", framing_rdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check_output(nm, framing_rdata, e);
        end
      end
    end
  endtask

  task automatic bus_idle();
    ce_d        = 1'b0;
    framing_sel = 1'b0;
    we_d        = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] addr, input string name, input logic [63:0] exp);
    @(negedge msoc_clk);
    ce_d = 1'b1; framing_sel = 1'b1; we_d = 1'b0; core_lsu_addr = addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge msoc_clk);
    bus_idle();
  endtask

  task automatic bus_write(input logic [13:0] addr, input logic [63:0] data);
    @(negedge msoc_clk);
    ce_d = 1'b1; framing_sel = 1'b1; we_d = 1'b1;
    core_lsu_addr = addr; core_lsu_wdata = data;
    @(negedge msoc_clk);
    bus_idle();
  endtask

  task automatic apply_stimulus(input int n, input int seed, input bit bad, input bit last);
    for (int i = 0; i < n; i++) begin
      @(negedge msoc_clk);
      rx_tvalid = 1'b1;
      rx_tdata  = 8'(seed + i);
      rx_tlast  = last && (i == n - 1);
      rx_tuser  = bad && last && (i == n - 1);
    end
  endtask

  task automatic stream_idle();
    @(negedge msoc_clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge msoc_clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tab[7];
    int   h;
    rstn = 1'b0;
    rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    core_lsu_addr = '0; core_lsu_wdata = '0;
    bus_idle();
    fork read_monitor(); join_none
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(1);
    check_output("rst_rdata", framing_rdata, 64'h0);
    check_output("rst_irq", 64'(eth_irq), 64'h0);
    bus_read(A_STATUS, "rst_status", 64'h0);

    // One good 64-byte frame, then the table of reads describing it.
    bus_write(A_CTRL, 64'h1);
    apply_stimulus(64, 0, 1'b0, 1'b1);
    stream_idle();
    tab[0] = '{A_STATUS, status_word(1, 0, 1, 0)};
    tab[1] = '{A_RXLEN, 64'h40};
    tab[2] = '{14'h0000, 64'h0706050403020100};
    tab[3] = '{14'h0038, pat_word(0, 7)};
    tab[4] = '{A_CTRL, 64'h1};
    tab[5] = '{14'h2000, 64'h0};
    tab[6] = '{14'h1030, 64'h0};
    for (int i = 0; i < 7; i++)
      bus_read(tab[i].addr, $sformatf("vec%0d", i), tab[i].exp);
    check_output("irq_set", 64'(eth_irq), 64'h1);
    bus_write(A_POP, 64'h0);
    wait_cycles(2);
    check_output("irq_clear", 64'(eth_irq), 64'h0);
    bus_read(A_STATUS, "status_after_pop", status_word(1, 1, 0, 0));

    // Five back-to-back frames into four slots: the fifth is dropped.
    for (int k = 0; k < 5; k++)
      apply_stimulus(60, 16*(k+1), 1'b0, 1'b1);
    stream_idle();
    bus_read(A_STATUS, "status_full", status_word(1, 1, 4, 1));
    check_output("irq_full", 64'(eth_irq), 64'h1);
    for (int k = 0; k < 4; k++) begin
      bus_read(A_RXLEN, $sformatf("b2b_len%0d", k), 64'h3C);
      bus_read(14'h0000, $sformatf("b2b_w0_%0d", k), pat_word(16*(k+1), 0));
      bus_read(14'h0030, $sformatf("b2b_w6_%0d", k), pat_word(16*(k+1), 6));
      bus_write(A_POP, 64'h0);
    end
    bus_read(A_STATUS, "status_drained", status_word(1, 1, 0, 1));
    wait_cycles(2);
    check_output("irq_drained", 64'(eth_irq), 64'h0);
    bus_write(A_DROPCLR, 64'h0);
    bus_read(A_STATUS, "status_dropclr", status_word(1, 1, 0, 0));

    // Oversized frame is truncated at the slot size and flagged.
    apply_stimulus(3000, 0, 1'b0, 1'b1);
    stream_idle();
    bus_read(A_RXLEN, "trunc_len", 64'h10800);
    bus_read(14'h0000, "trunc_w0", pat_word(0, 0));
    bus_read(14'h0400, "trunc_w128", pat_word(0, 128));
    bus_read(14'h07F8, "trunc_w255", 64'hFFFEFDFCFBFAF9F8);
    bus_write(A_POP, 64'h0);

    // Frame with bad FCS.
    apply_stimulus(20, 8'hC0, 1'b1, 1'b1);
    stream_idle();
`ifdef FRAMING_RX_BADFRAME_DROP_EN
    bus_read(A_STATUS, "bad_dropped", status_word(2, 2, 0, 1));
    bus_write(A_DROPCLR, 64'h0);
    h = 2;
`else
    bus_read(A_STATUS, "bad_committed", status_word(3, 2, 1, 0));
    bus_read(A_RXLEN, "bad_len", 64'h10014);
    bus_write(A_POP, 64'h0);
    h = 3;
`endif

    // Commit and POP in the same cycle leave count unchanged.
    apply_stimulus(16, 8'h60, 1'b0, 1'b1);
    apply_stimulus(16, 8'h70, 1'b0, 1'b1);
    apply_stimulus(16, 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge msoc_clk);
      rx_tvalid = 1'b1; rx_tdata = 8'(8'h90 + i); rx_tlast = (i == 15); rx_tuser = 1'b0;
      if (i == 15) begin
        ce_d = 1'b1; framing_sel = 1'b1; we_d = 1'b1; core_lsu_addr = A_POP;
      end
    end
    stream_idle();
    bus_idle();
    bus_read(A_STATUS, "commit_pop", status_word((h+4)%4, (h+1)%4, 3, 0));
    bus_read(A_RXLEN, "commit_pop_len", 64'h10);
    bus_read(14'h0000, "commit_pop_w0", pat_word(8'h70, 0));

    // POP on the first byte of a frame arriving while full does not save it.
    apply_stimulus(16, 8'hA0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge msoc_clk);
      rx_tvalid = 1'b1; rx_tdata = 8'(8'hB0 + i); rx_tlast = (i == 15); rx_tuser = 1'b0;
      if (i == 0) begin
        ce_d = 1'b1; framing_sel = 1'b1; we_d = 1'b1; core_lsu_addr = A_POP;
      end else begin
        bus_idle();
      end
    end
    stream_idle();
    bus_read(A_STATUS, "full_pop_drop", status_word((h+5)%4, (h+2)%4, 3, 1));
    for (int k = 0; k < 3; k++)
      bus_write(A_POP, 64'h0);
    bus_read(A_STATUS, "drained2", status_word((h+5)%4, (h+5)%4, 0, 1));
    bus_write(A_POP, 64'h0);
    bus_read(A_STATUS, "pop_empty", status_word((h+5)%4, (h+5)%4, 0, 1));

    // Reset in the middle of a frame; the remainder becomes a frame of its own.
    bus_write(A_CTRL, 64'h1);
    apply_stimulus(30, 0, 1'b0, 1'b0);
    @(negedge msoc_clk);
    rx_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    check_output("midrst_rdata", framing_rdata, 64'h0);
    check_output("midrst_irq", 64'(eth_irq), 64'h0);
    wait_cycles(2);
    rstn = 1'b1;
    apply_stimulus(30, 30, 1'b0, 1'b1);
    stream_idle();
    bus_read(A_STATUS, "midrst_status", status_word(1, 0, 1, 0));
    bus_read(A_RXLEN, "midrst_len", 64'h1E);
    bus_read(14'h0000, "midrst_w0", 64'h2524232221201F1E);
    bus_read(A_CTRL, "midrst_ctrl", 64'h0);

    wait_cycles(2);
    check_output("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
